// File: rtl/matrix_pkg.sv
// Shared constants, frame type and FSM state encoding for the LED matrix scan driver.
package matrix_pkg;

    localparam int unsigned NUM_COLS  = 32;
    localparam int unsigned NUM_ROWS  = 16;
    localparam int unsigned SCAN_ROWS = 8;
    localparam int unsigned COL_W     = $clog2(NUM_COLS);
    localparam int unsigned ROW_W     = $clog2(SCAN_ROWS);

    // Bit positions inside rgb = {R1,G1,B1,R2,G2,B2}
    localparam int unsigned RGB_R1 = 5;
    localparam int unsigned RGB_G1 = 4;
    localparam int unsigned RGB_B1 = 3;
    localparam int unsigned RGB_R2 = 2;
    localparam int unsigned RGB_G2 = 1;
    localparam int unsigned RGB_B2 = 0;

    // frame[c][r]: column c, row r
    typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] frame_t;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch,
        StDisplay
    } state_e;

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Panel-side bundle of the scan driver: frame input, enable and HUB75-style outputs.
interface matrix_scan_driver_if;
    import matrix_pkg::*;

    logic       en;
    frame_t     matrix;
    logic [5:0] rgb;
    logic       sclk;
    logic       lat;
    logic       oe;
    logic [2:0] abc;
    logic       frame_done;

    modport master (
        input  en, matrix,
        output rgb, sclk, lat, oe, abc, frame_done
    );

    modport slave (
        output en, matrix,
        input  rgb, sclk, lat, oe, abc, frame_done
    );

endinterface

// File: rtl/pixel_colorizer.sv
// Maps the snapshot pixels of one column / row pair to panel colour bits.
// Optional build macro BORDER_EN paints the outer frame green.
module pixel_colorizer
    import matrix_pkg::*;
(
    input  frame_t           snap,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    output logic [5:0]       rgb
);

    logic top;
    logic bot;

    always_comb begin
        top = snap[col][{1'b0, row}];
        bot = snap[col][{1'b1, row}];
        rgb = '0;
        rgb[RGB_R1] = top;
        rgb[RGB_R2] = bot;
`ifdef BORDER_EN
        if (col == '0 || col == COL_W'(NUM_COLS - 1) || row == '0) begin
            rgb[RGB_R1] = 1'b0;
            rgb[RGB_G1] = 1'b1;
            rgb[RGB_B1] = 1'b0;
        end
        // Bottom half reaches the last panel row on the final row pair
        if (col == '0 || col == COL_W'(NUM_COLS - 1) || row == ROW_W'(SCAN_ROWS - 1)) begin
            rgb[RGB_R2] = 1'b0;
            rgb[RGB_G2] = 1'b1;
            rgb[RGB_B2] = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// 1/8-scan driver for a 32x16 LED panel: shift a row pair, latch it, light it for ON_CYCLES.
// Build macro BORDER_EN (see pixel_colorizer) adds a green border.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int unsigned ON_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    matrix_scan_driver_if.master bus
);

    localparam int unsigned CNT_W = 10;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    frame_t           snap_q, snap_d;

    logic [5:0]       rgb_q, rgb_d;
    logic             sclk_q, sclk_d;
    logic             lat_q, lat_d;
    logic             oe_q, oe_d;
    logic [2:0]       abc_q, abc_d;
    logic             fd_q, fd_d;

    logic [5:0]       pix_rgb;
    logic             on_last;

    assign on_last = (cnt_q == CNT_W'(ON_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        fd_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.en) begin
                    state_d = StShift;
                    row_d   = '0;
                    col_d   = '0;
                    phase_d = 1'b0;
                    snap_d  = bus.matrix;
                end
            end
            StShift: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (col_q == COL_W'(NUM_COLS - 1)) begin
                        state_d = StLatch;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StLatch: begin
                state_d = StDisplay;
                cnt_d   = '0;
            end
            StDisplay: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (on_last) begin
                    col_d   = '0;
                    phase_d = 1'b0;
                    if (row_q == ROW_W'(SCAN_ROWS - 1)) begin
                        fd_d   = 1'b1;
                        row_d  = '0;
                        snap_d = bus.matrix;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    if (bus.en) begin
                        state_d = StShift;
                    end else begin
                        // Stopping mid-frame: the next enable starts over at row pair 0
                        state_d = StIdle;
                        row_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    pixel_colorizer u_colorizer (
        .snap (snap_d),
        .col  (col_d),
        .row  (row_d),
        .rgb  (pix_rgb)
    );

    always_comb begin
        rgb_d  = (state_d == StShift) ? pix_rgb : '0;
        sclk_d = (state_d == StShift) && phase_d;
        lat_d  = (state_d == StLatch);
        oe_d   = (state_d != StDisplay);
        abc_d  = (state_d == StLatch || state_d == StDisplay) ? row_d : abc_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            snap_q  <= '0;
            rgb_q   <= '0;
            sclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            oe_q    <= 1'b1;
            abc_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            rgb_q   <= rgb_d;
            sclk_q  <= sclk_d;
            lat_q   <= lat_d;
            oe_q    <= oe_d;
            abc_q   <= abc_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.rgb        = rgb_q;
    assign bus.sclk       = sclk_q;
    assign bus.lat        = lat_q;
    assign bus.oe         = oe_q;
    assign bus.abc        = abc_q;
    assign bus.frame_done = fd_q;

endmodule
